// File: rtl/pu_or1k_spr_sysgrp_pkg.sv
// Shared OR1K SPR field definitions and the group-0 (system) register index map.
package pu_or1k_spr_sysgrp_pkg;

    localparam int OR1K_SPR_GROUP_MSB = 15;
    localparam int OR1K_SPR_GROUP_LSB = 11;
    localparam int OR1K_SPR_INDEX_W   = 11;

    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_VR       = 11'd0;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_UPR      = 11'd1;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_CPUCFGR  = 11'd2;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_DMMUCFGR = 11'd3;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_IMMUCFGR = 11'd4;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_DCCFGR   = 11'd5;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_ICCFGR   = 11'd6;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_DCFGR    = 11'd7;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_PCCFGR   = 11'd8;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_VR2      = 11'd9;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_AVR      = 11'd10;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_EVBAR    = 11'd11;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_AECR     = 11'd12;
    localparam logic [OR1K_SPR_INDEX_W-1:0] SPR_SYS_AESR     = 11'd13;

    // EVBAR holds an 8 KiB-aligned vector base; the low 13 bits are hardwired to 0.
    localparam logic [31:0] SPR_EVBAR_MASK = 32'hFFFF_E000;

    function automatic logic spr_is_group0(input logic [15:0] addr);
        return addr[OR1K_SPR_GROUP_MSB:OR1K_SPR_GROUP_LSB] == '0;
    endfunction

endpackage

// File: rtl/pu_or1k_spr_sysgrp_regs.sv
// Writable group-0 register bank: EVBAR, AECR and the sticky AESR.
module pu_or1k_spr_sysgrp_regs
    import pu_or1k_spr_sysgrp_pkg::*;
#(
    parameter bit HAS_EVBAR = 1'b0,
    parameter bit HAS_AECSR = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_evbar_i,
    input  logic        wr_aecr_i,
    input  logic        wr_aesr_i,
    input  logic [31:0] wr_dat_i,
    input  logic [31:0] aesr_set_i,
    output logic [31:0] evbar_o,
    output logic [31:0] aecr_o,
    output logic [31:0] aesr_o
);

    logic [31:0] evbar_q, evbar_d;
    logic [31:0] aecr_q, aecr_d;
    logic [31:0] aesr_q, aesr_d;
    logic [31:0] aesr_events;

    // Only exceptions enabled in the current AECR latch into AESR.
    assign aesr_events = aesr_set_i & aecr_q;

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and infers a latch.
        evbar_d = evbar_q;
        aecr_d  = aecr_q;
        aesr_d  = aesr_q | aesr_events;
        if (wr_evbar_i) evbar_d = wr_dat_i & SPR_EVBAR_MASK;
        if (wr_aecr_i)  aecr_d  = wr_dat_i;
        if (wr_aesr_i)  aesr_d  = wr_dat_i | aesr_events;
        if (!HAS_EVBAR) evbar_d = '0;
        if (!HAS_AECSR) begin
            aecr_d = '0;
            aesr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            evbar_q <= '0;
            aecr_q  <= '0;
            aesr_q  <= '0;
        end else begin
            evbar_q <= evbar_d;
            aecr_q  <= aecr_d;
            aesr_q  <= aesr_d;
        end
    end

    assign evbar_o = evbar_q;
    assign aecr_o  = aecr_q;
    assign aesr_o  = aesr_q;

endmodule

// File: rtl/pu_or1k_spr_sysgrp.sv
// SPR group-0 access unit: answers mfspr/mtspr over a strobe/ack bus with registered read data.
module pu_or1k_spr_sysgrp
    import pu_or1k_spr_sysgrp_pkg::*;
#(
    parameter string FEATURE_EVBAR = "NONE",
    parameter string FEATURE_AECSR = "NONE"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] spr_bus_addr_i,
    input  logic        spr_bus_stb_i,
    input  logic        spr_bus_we_i,
    input  logic [31:0] spr_bus_dat_i,
    output logic [31:0] spr_bus_dat_o,
    output logic        spr_bus_ack_o,
    output logic        spr_err_o,
    input  logic        supervisor_mode_i,
    input  logic [31:0] spr_vr_i,
    input  logic [31:0] spr_vr2_i,
    input  logic [31:0] spr_upr_i,
    input  logic [31:0] spr_cpucfgr_i,
    input  logic [31:0] spr_dmmucfgr_i,
    input  logic [31:0] spr_immucfgr_i,
    input  logic [31:0] spr_dccfgr_i,
    input  logic [31:0] spr_iccfgr_i,
    input  logic [31:0] spr_dcfgr_i,
    input  logic [31:0] spr_pccfgr_i,
    input  logic [31:0] spr_avr_i,
    input  logic [31:0] aesr_set_i,
    output logic [31:0] spr_evbar_o,
    output logic [31:0] spr_aecr_o,
    output logic [31:0] spr_aesr_o
);

    localparam bit HAS_EVBAR = (FEATURE_EVBAR != "NONE");
    localparam bit HAS_AECSR = (FEATURE_AECSR != "NONE");

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;

    logic [OR1K_SPR_INDEX_W-1:0] idx;
    logic        accept;
    logic        wr_ok;
    logic        commit;
    logic [31:0] rd_data;
    logic [31:0] evbar, aecr, aesr;

    assign idx    = spr_bus_addr_i[OR1K_SPR_INDEX_W-1:0];
    assign accept = (state_q == ST_IDLE) && spr_bus_stb_i && spr_is_group0(spr_bus_addr_i);
    assign commit = accept && spr_bus_we_i && wr_ok;

    // Absent optional registers are held at zero in the bank, so they read back 0.
    always_comb begin
        rd_data = '0;
        case (idx)
            SPR_SYS_VR:       rd_data = spr_vr_i;
            SPR_SYS_UPR:      rd_data = spr_upr_i;
            SPR_SYS_CPUCFGR:  rd_data = spr_cpucfgr_i;
            SPR_SYS_DMMUCFGR: rd_data = spr_dmmucfgr_i;
            SPR_SYS_IMMUCFGR: rd_data = spr_immucfgr_i;
            SPR_SYS_DCCFGR:   rd_data = spr_dccfgr_i;
            SPR_SYS_ICCFGR:   rd_data = spr_iccfgr_i;
            SPR_SYS_DCFGR:    rd_data = spr_dcfgr_i;
            SPR_SYS_PCCFGR:   rd_data = spr_pccfgr_i;
            SPR_SYS_VR2:      rd_data = spr_vr2_i;
            SPR_SYS_AVR:      rd_data = spr_avr_i;
            SPR_SYS_EVBAR:    rd_data = evbar;
            SPR_SYS_AECR:     rd_data = aecr;
            SPR_SYS_AESR:     rd_data = aesr;
            default:          rd_data = '0;
        endcase
    end

    always_comb begin
        wr_ok = 1'b0;
        case (idx)
            SPR_SYS_EVBAR:               wr_ok = HAS_EVBAR;
            SPR_SYS_AECR, SPR_SYS_AESR:  wr_ok = HAS_AECSR;
            default:                     wr_ok = 1'b0;
        endcase
        wr_ok = wr_ok && supervisor_mode_i;
    end

    // A strobe seen in RESP is ignored; the requester re-presents it and is served two cycles later.
    always_comb begin
        state_d = (state_q == ST_IDLE && accept) ? ST_RESP : ST_IDLE;
        ack_d   = accept;
        err_d   = accept && spr_bus_we_i && !wr_ok;
        dat_d   = accept ? rd_data : dat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    pu_or1k_spr_sysgrp_regs #(
        .HAS_EVBAR (HAS_EVBAR),
        .HAS_AECSR (HAS_AECSR)
    ) u_regs (
        .clk        (clk),
        .rst        (rst),
        .wr_evbar_i (commit && idx == SPR_SYS_EVBAR),
        .wr_aecr_i  (commit && idx == SPR_SYS_AECR),
        .wr_aesr_i  (commit && idx == SPR_SYS_AESR),
        .wr_dat_i   (spr_bus_dat_i),
        .aesr_set_i (aesr_set_i),
        .evbar_o    (evbar),
        .aecr_o     (aecr),
        .aesr_o     (aesr)
    );

    assign spr_bus_dat_o = dat_q;
    assign spr_bus_ack_o = ack_q;
    assign spr_err_o     = err_q;
    assign spr_evbar_o   = evbar;
    assign spr_aecr_o    = aecr;
    assign spr_aesr_o    = aesr;

endmodule

// File: tb/tb_pu_or1k_spr_sysgrp.sv
// Bench for the SPR group-0 unit: one instance with all optional registers, one with none.
module tb_pu_or1k_spr_sysgrp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] addr;
    logic        stb, we, sup;
    logic [31:0] wdat, aesr_set;
    logic [31:0] cfg [11];

    logic [31:0] dat_o [2];
    logic        ack   [2];
    logic        err   [2];
    logic [31:0] evbar [2];
    logic [31:0] aecr  [2];
    logic [31:0] aesr  [2];

    pu_or1k_spr_sysgrp #(.FEATURE_EVBAR("ENABLED"), .FEATURE_AECSR("ENABLED")) dut_full (
        .clk(clk), .rst(rst),
        .spr_bus_addr_i(addr), .spr_bus_stb_i(stb), .spr_bus_we_i(we), .spr_bus_dat_i(wdat),
        .spr_bus_dat_o(dat_o[0]), .spr_bus_ack_o(ack[0]), .spr_err_o(err[0]),
        .supervisor_mode_i(sup),
        .spr_vr_i(cfg[0]), .spr_vr2_i(cfg[9]), .spr_upr_i(cfg[1]), .spr_cpucfgr_i(cfg[2]),
        .spr_dmmucfgr_i(cfg[3]), .spr_immucfgr_i(cfg[4]), .spr_dccfgr_i(cfg[5]),
        .spr_iccfgr_i(cfg[6]), .spr_dcfgr_i(cfg[7]), .spr_pccfgr_i(cfg[8]), .spr_avr_i(cfg[10]),
        .aesr_set_i(aesr_set),
        .spr_evbar_o(evbar[0]), .spr_aecr_o(aecr[0]), .spr_aesr_o(aesr[0])
    );

    pu_or1k_spr_sysgrp #(.FEATURE_EVBAR("NONE"), .FEATURE_AECSR("NONE")) dut_none (
        .clk(clk), .rst(rst),
        .spr_bus_addr_i(addr), .spr_bus_stb_i(stb), .spr_bus_we_i(we), .spr_bus_dat_i(wdat),
        .spr_bus_dat_o(dat_o[1]), .spr_bus_ack_o(ack[1]), .spr_err_o(err[1]),
        .supervisor_mode_i(sup),
        .spr_vr_i(cfg[0]), .spr_vr2_i(cfg[9]), .spr_upr_i(cfg[1]), .spr_cpucfgr_i(cfg[2]),
        .spr_dmmucfgr_i(cfg[3]), .spr_immucfgr_i(cfg[4]), .spr_dccfgr_i(cfg[5]),
        .spr_iccfgr_i(cfg[6]), .spr_dcfgr_i(cfg[7]), .spr_pccfgr_i(cfg[8]), .spr_avr_i(cfg[10]),
        .aesr_set_i(aesr_set),
        .spr_evbar_o(evbar[1]), .spr_aecr_o(aecr[1]), .spr_aesr_o(aesr[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Transaction-level reference model, one copy per configuration.
    bit          has_ev [2] = '{1'b1, 1'b0};
    bit          has_ae [2] = '{1'b1, 1'b0};
    logic [31:0] m_evbar[2] = '{default: '0};
    logic [31:0] m_aecr [2] = '{default: '0};
    logic [31:0] m_aesr [2] = '{default: '0};
    logic [31:0] m_dat  [2] = '{default: '0};
    bit          m_ack  [2] = '{default: 1'b0};
    bit          m_err  [2] = '{default: 1'b0};
    bit          m_busy [2] = '{default: 1'b0};
    bit          chk_en = 1'b0;

    function automatic logic [31:0] model_read(input int d, input int i);
        if (i <= 10) return cfg[i];
        if (i == 11) return has_ev[d] ? m_evbar[d] : 32'h0;
        if (i == 12) return has_ae[d] ? m_aecr[d] : 32'h0;
        if (i == 13) return has_ae[d] ? m_aesr[d] : 32'h0;
        return 32'h0;
    endfunction

    function automatic bit model_legal(input int d, input int i);
        if (!sup) return 1'b0;
        return (i == 11 && has_ev[d]) || ((i == 12 || i == 13) && has_ae[d]);
    endfunction

    always @(posedge clk) begin
        int          i;
        bit          acc;
        logic [31:0] next_aesr;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_evbar[d] = 0; m_aecr[d] = 0; m_aesr[d] = 0; m_dat[d] = 0;
                m_ack[d] = 0; m_err[d] = 0; m_busy[d] = 0;
            end else begin
                i   = int'(addr[10:0]);
                acc = !m_busy[d] && stb && (addr[15:11] == 5'd0);
                next_aesr = has_ae[d] ? (m_aesr[d] | (aesr_set & m_aecr[d])) : 32'h0;
                m_ack[d] = acc;
                m_err[d] = acc && we && !model_legal(d, i);
                if (acc) m_dat[d] = model_read(d, i);
                if (acc && we && model_legal(d, i)) begin
                    if (i == 11) m_evbar[d] = wdat & 32'hFFFF_E000;
                    if (i == 12) m_aecr[d] = wdat;
                    if (i == 13) next_aesr = wdat | (aesr_set & m_aecr[d]);
                end
                m_aesr[d] = next_aesr;
                m_busy[d] = acc;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("ack[%0d]", d),   {31'b0, ack[d]}, {31'b0, m_ack[d]});
                check($sformatf("err[%0d]", d),   {31'b0, err[d]}, {31'b0, m_err[d]});
                check($sformatf("dat[%0d]", d),   dat_o[d], m_dat[d]);
                check($sformatf("evbar[%0d]", d), evbar[d], m_evbar[d]);
                check($sformatf("aecr[%0d]", d),  aecr[d],  m_aecr[d]);
                check($sformatf("aesr[%0d]", d),  aesr[d],  m_aesr[d]);
            end
        end
    end

    logic [31:0] rd0, rd1;
    logic        ak0, er0, er1;

    task automatic access(input logic [15:0] a, input logic w, input logic [31:0] dv,
                          input logic s, input logic [31:0] setv);
        @(negedge clk);
        addr = a; we = w; wdat = dv; sup = s; aesr_set = setv; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0; aesr_set = '0;
        rd0 = dat_o[0]; rd1 = dat_o[1]; ak0 = ack[0]; er0 = err[0]; er1 = err[1];
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; wdat = '0; sup = 1'b1; aesr_set = '0;
        for (int i = 0; i < 11; i++) cfg[i] = $urandom | 32'h1;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset ack", {31'b0, ack[0]}, 32'h0);
        check("reset dat", dat_o[0], 32'h0);
        check("reset evbar", evbar[0], 32'h0);
        check("reset aecr", aecr[0], 32'h0);
        check("reset aesr", aesr[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Read sweep across the whole map plus two unmapped indices.
        for (int i = 0; i < 14; i++) begin
            access(16'(i), 1'b0, 32'h0, 1'b1, 32'h0);
            check($sformatf("sweep ack %0d", i), {31'b0, ak0}, 32'h1);
            check($sformatf("sweep data %0d", i), rd0, (i <= 10) ? cfg[i] : 32'h0);
        end
        access(16'd14, 1'b0, 32'h0, 1'b1, 32'h0);
        check("read idx14", rd0, 32'h0);
        check("read idx14 err", {31'b0, er0}, 32'h0);
        access(16'h07FF, 1'b0, 32'h0, 1'b1, 32'h0);
        check("read 0x7ff", rd0, 32'h0);
        check("read 0x7ff err", {31'b0, er0}, 32'h0);

        // Illegal writes.
        access(16'd1, 1'b1, 32'h1234, 1'b1, 32'h0);
        check("upr write ack", {31'b0, ak0}, 32'h1);
        check("upr write err", {31'b0, er0}, 32'h1);
        access(16'd1, 1'b0, 32'h0, 1'b1, 32'h0);
        check("upr unchanged", rd0, cfg[1]);
        access(16'd12, 1'b1, 32'hFFFF_0000, 1'b0, 32'h0);
        check("user aecr err", {31'b0, er0}, 32'h1);
        check("user aecr kept", aecr[0], 32'h0);

        // EVBAR write in both configurations.
        access(16'd11, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0);
        check("evbar err full", {31'b0, er0}, 32'h0);
        check("evbar err none", {31'b0, er1}, 32'h1);
        check("evbar out", evbar[0], 32'hDEAD_A000);
        access(16'd11, 1'b0, 32'h0, 1'b1, 32'h0);
        check("evbar read full", rd0, 32'hDEAD_A000);
        check("evbar read none", rd1, 32'h0);

        // AESR sticky behaviour under AECR = 5.
        access(16'd12, 1'b1, 32'h5, 1'b1, 32'h0);
        @(negedge clk); aesr_set = 32'h7;
        @(negedge clk); aesr_set = 32'h0;
        check("aesr set", aesr[0], 32'h5);
        repeat (3) @(negedge clk);
        check("aesr sticky", aesr[0], 32'h5);
        access(16'd13, 1'b1, 32'h0, 1'b1, 32'h1);
        check("aesr write+set", aesr[0], 32'h1);

        // Strobe held high: accesses every other cycle.
        @(negedge clk);
        addr = 16'd0; we = 1'b0; stb = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("held stb ack c%0d", c), {31'b0, ack[0]}, (c % 2 == 1) ? 32'h1 : 32'h0);
        end
        @(negedge clk); stb = 1'b0;
        @(negedge clk);

        // Other group never acknowledged.
        addr = 16'h0800; stb = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("group1 ack c%0d", c), {31'b0, ack[0] | ack[1]}, 32'h0);
        end
        stb = 1'b0;

        // Reset coincident with a write acceptance.
        @(negedge clk);
        addr = 16'd12; we = 1'b1; wdat = 32'hFFFF_FFFF; sup = 1'b1; stb = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("rst aecr", aecr[0], 32'h0);
        check("rst ack", {31'b0, ack[0]}, 32'h0);
        rst = 1'b0; stb = 1'b0;
        access(16'd12, 1'b0, 32'h0, 1'b1, 32'h0);
        check("post-rst ack", {31'b0, ak0}, 32'h1);
        check("post-rst aecr read", rd0, 32'h0);

        // Randomized traffic against the model.
        repeat (600) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 59) == 0);
            stb  = $urandom_range(0, 2) != 0;
            we   = $urandom_range(0, 1) != 0;
            sup  = $urandom_range(0, 3) != 0;
            wdat = $urandom;
            aesr_set = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 9) < 8) addr = 16'($urandom_range(0, 15));
            else addr = 16'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; stb = 1'b0; aesr_set = '0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pu_or1k_spr_sysgrp.md
# pu_or1k_spr_sysgrp

SPR group-0 access unit for the processing unit. It sits directly downstream of the configuration-register generator. It consumes the constant VR/VR2/UPR/CPUCFGR/DMMUCFGR/IMMUCFGR/DCCFGR/ICCFGR/DCFGR/PCCFGR/AVR words, and it holds the writable group-0 registers EVBAR, AECR and AESR. It answers l.mfspr/l.mtspr traffic from the control stage over a strobe/ack SPR bus with registered read data.

## Interface
- FEATURE_EVBAR, "NONE", EVBAR register present when != "NONE"
- FEATURE_AECSR, "NONE", AECR/AESR present when != "NONE"
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- spr_bus_addr_i  in  16  SPR address; group = [15:11], index = [10:0]
- spr_bus_stb_i  in  1  request strobe, held by requester until ack
- spr_bus_we_i  in  1  1 = write (mtspr), 0 = read (mfspr)
- spr_bus_dat_i  in  32  write data
- spr_bus_dat_o  out  32  registered read data, valid with ack
- spr_bus_ack_o  out  1  one-cycle acknowledge
- spr_err_o  out  1  one-cycle illegal-write flag, coincident with ack
- supervisor_mode_i  in  1  SR[SM]; writes allowed only when 1
- spr_vr_i, spr_vr2_i, spr_upr_i, spr_cpucfgr_i, spr_dmmucfgr_i, spr_immucfgr_i, spr_dccfgr_i, spr_iccfgr_i, spr_dcfgr_i, spr_pccfgr_i, spr_avr_i  in  32 each  config words, treated as static
- aesr_set_i  in  32  per-bit arithmetic-exception events from the execute stage
- spr_evbar_o  out  32  current EVBAR (bits [12:0] always 0)
- spr_aecr_o  out  32  current AECR
- spr_aesr_o  out  32  current AESR

## Operation
- Select is `stb & (addr[15:11] == 0)`. Requests to other groups are ignored: no ack, no state change.
- Index map:
  - 0 VR, 1 UPR, 2 CPUCFGR, 3 DMMUCFGR, 4 IMMUCFGR, 5 DCCFGR, 6 ICCFGR, 7 DCFGR, 8 PCCFGR
  - 9 VR2, 10 AVR, 11 EVBAR, 12 AECR, 13 AESR
  - any other index reads 0.
- FSM has two states, IDLE and RESP.
  - IDLE & select: capture read data into spr_bus_dat_o, commit any write, go to RESP.
  - RESP: ack = 1, err as computed, return to IDLE unconditionally. A strobe sampled in RESP is ignored.
- Writes:
  - EVBAR takes dat_i[31:13]; bits [12:0] are forced to 0.
  - AECR takes all 32 bits.
  - AESR takes dat_i OR (aesr_set_i & AECR) in the commit cycle.
- Illegal write: any of the following still acks, makes no state change, and sets err = 1.
  - write to indices 0–10
  - write to an unmapped index
  - write to an absent EVBAR/AECR/AESR
  - any write with supervisor_mode_i = 0
- Reads from an absent EVBAR/AECR/AESR return 0. Reads never assert err.
- AESR update when no write is committed: AESR |= aesr_set_i & AECR, every cycle. AESR bits are sticky until written.
- Read data in the capture cycle reflects register values before that edge; the same-edge AESR set is not visible in the data.

## Timing
- Reset values:
  - state IDLE
  - spr_bus_ack_o 0, spr_err_o 0, spr_bus_dat_o 0
  - EVBAR 0, AECR 0, AESR 0
- Latency: stb sampled high in IDLE at edge N gives ack/dat/err valid in cycle N+1. The minimum spacing between accesses is 2 cycles.
- Back-to-back: if the requester keeps stb high through cycle N+1, the second access is accepted at edge N+2.
- A write commits at acceptance edge N. Outputs spr_evbar_o/aecr_o/aesr_o show the new value from cycle N+1.
- Reset mid-operation:
  - rst at edge N cancels the pending acceptance and its write.
  - rst while in RESP drops ack in the following cycle.
- spr_bus_dat_o holds its last value outside ack cycles.

## Structure
- Group-0 index constants (VR … AESR), the SPR group field range and the EVBAR valid-bit mask go in the shared defines/package next to the existing OR1K_SPR_* field macros.
- FSM state enum is local.
- No sub-module is needed. The writable-register bank may be split into pu_or1k_spr_sysgrp_regs (EVBAR/AECR/AESR plus sticky logic) if the top exceeds ~250 lines.

## Test plan
- Read sweep: for each index 0–13, drive distinct patterns on the config inputs and read. Expected: ack exactly 1 cycle after acceptance with the matching word. Index 14 and 0x7FF read 0x0, err 0.
- EVBAR write with FEATURE_EVBAR="ENABLED", supervisor 1: write 0xDEAD_BEEF. Expected: spr_evbar_o = 0xDEAD_A000 next cycle and readback equal; with "NONE", readback 0 and err 1.
- Illegal writes:
  - write 0x1234 to UPR (index 1): expected ack, err 1, UPR read unchanged.
  - write AECR in user mode: expected ack, err 1, AECR stays 0.
- AESR sticky, with AECR = 0x0000_0005: pulse aesr_set_i = 0x7 for 1 cycle. Expected: AESR = 0x5 and it persists. Then write AESR 0x0 while setting 0x1 in the same cycle. Expected: AESR = 0x1.
- Handshake:
  - stb held high for 5 cycles: expected ack in cycles 1 and 3 only.
  - group-1 address (0x0800): expected no ack, ever.
- Reset: assert rst coincident with a write acceptance of AECR = 0xFFFF_FFFF. Expected: AECR 0, ack 0 next cycle, state IDLE.
